// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped data cache.
//   - Address split: tag [31:9], index [8:5], offset [4:0] (word select [4:2]).
//   - Default line width (32-byte line) and controller state encoding.
package dcache_pkg;

  localparam int ADDR_W = 32;
  localparam int TAG_W  = 23;
  localparam int IDX_W  = 4;
  localparam int OFS_W  = 5;
  localparam int WORD_W = 32;
  localparam int WSEL_W = 3;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2,
    S_FILL_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: line storage for the direct-mapped cache.
//   Single port addressed by idx. Reads (tag, data, valid, dirty) are
//   combinational; a write (wr_en) replaces tag and data, sets valid and
//   loads the dirty bit from wr_dirty at the rising edge.
//   Only valid/dirty are reset; tag and data keep their contents and become
//   unreachable once their valid bit is cleared.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int LINE_W    = dcache_pkg::LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              wr_dirty,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_q[idx]  <= wr_tag;
      data_q[idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back data cache controller.
//   CPU side : cpu_addr_i, cpu_MemRead_i, cpu_MemWrite_i, cpu_data_i in;
//              cpu_data_o (load word), cpu_stall_o (pipeline hold) out.
//   Memory   : mem_enable_o, mem_write_o, mem_addr_o, mem_data_o out
//              (line-granular request); mem_data_i, mem_ack_i in.
//   Hits complete in the request cycle. A miss optionally writes back the
//   dirty victim, refills the line, then spends one FILL_DONE cycle before
//   the request replays as a hit. The address is used live; the CPU holds it
//   stable while stalled.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int LINE_W    = dcache_pkg::LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [WSEL_W-1:0] sel,
                                                   input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] m;
    m = line;
    m[sel*WORD_W +: WORD_W] = word;
    return m;
  endfunction

  state_t state;

  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] wsel;
  logic              unused_byte_ofs;

  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;

  logic              req, hit, miss, victim_dirty;
  logic              wb_ack, refill_ack, store_hit;
  logic              sram_we;
  logic [LINE_W-1:0] sram_wdata;

  assign addr_tag        = cpu_addr_i[31:9];
  assign idx             = cpu_addr_i[8:5];
  assign wsel            = cpu_addr_i[4:2];
  assign unused_byte_ofs = ^cpu_addr_i[1:0];

  // A simultaneous read+write is a store: cpu_MemWrite_i alone selects the merge path.
  assign req          = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit          = req & rd_valid & (rd_tag == addr_tag);
  assign miss         = (state == S_IDLE) & req & ~hit;
  assign victim_dirty = rd_valid & rd_dirty;
  assign wb_ack       = (state == S_WRITEBACK) & mem_ack_i;
  assign refill_ack   = (state == S_REFILL) & mem_ack_i;
  assign store_hit    = (state == S_IDLE) & hit & cpu_MemWrite_i;

  assign cpu_stall_o = (state != S_IDLE) | (req & ~hit);
  assign cpu_data_o  = rd_data[wsel*WORD_W +: WORD_W];

  // Refill writes a clean line; a store hit writes the merged line dirty.
  assign sram_we    = refill_ack | store_hit;
  assign sram_wdata = refill_ack ? mem_data_i : merge_word(rd_data, wsel, cpu_data_i);

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_W)
  ) u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .idx      (idx),
    .wr_en    (sram_we),
    .wr_tag   (addr_tag),
    .wr_data  (sram_wdata),
    .wr_dirty (~refill_ack),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss) begin
            mem_enable_o <= 1'b1;
            mem_write_o  <= victim_dirty;
            state        <= victim_dirty ? S_WRITEBACK : S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            mem_write_o <= 1'b0;
            state       <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            state        <= S_FILL_DONE;
          end
        end
        S_FILL_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

  // Request address/data are captured on the transition into each transfer
  // and held until the matching ack; they carry no reset.
  always_ff @(posedge clk_i) begin
    if (miss && victim_dirty) begin
      mem_addr_o <= {rd_tag, idx, 5'b0};
      mem_data_o <= rd_data;
    end else if ((miss && !victim_dirty) || wb_ack) begin
      mem_addr_o <= {addr_tag, idx, 5'b0};
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: self-checking bench for dcache_ctrl.
//   Directed scenarios (cold miss, store/load hit, dirty eviction, spurious
//   ack, read+write as store, reset during refill) followed by randomized
//   accesses, all checked against a behavioural cache + memory model.
module tb_dcache_ctrl;

  localparam int LW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [31:0]   cpu_addr_i;
  logic          cpu_MemRead_i;
  logic          cpu_MemWrite_i;
  logic [31:0]   cpu_data_i;
  logic [31:0]   cpu_data_o;
  logic          cpu_stall_o;
  logic          mem_enable_o;
  logic          mem_write_o;
  logic [31:0]   mem_addr_o;
  logic [LW-1:0] mem_data_o;
  logic [LW-1:0] mem_data_i;
  logic          mem_ack_i;

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: cache contents and backing memory (keyed by line address).
  bit            m_valid [16];
  bit            m_dirty [16];
  logic [22:0]   m_tag   [16];
  logic [LW-1:0] m_data  [16];
  logic [LW-1:0] mem     [int unsigned];

  function automatic logic [LW-1:0] mem_get(input logic [31:0] la);
    logic [LW-1:0] l;
    if (mem.exists(la)) return mem[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = la ^ (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // One CPU access, held until the stall drops; acts as the memory with the
  // given ack latencies (ack in the Nth cycle a transfer is requested).
  task automatic access(input logic [31:0] a, input bit rd, input bit wr,
                        input logic [31:0] d, input int lat_wb, input int lat_rf);
    logic [3:0]    ix;
    logic [22:0]   tg;
    int            w;
    bit            hitm, exp_wb, done;
    logic [31:0]   exp_wb_addr, exp_rf_addr, exp_rdata;
    logic [LW-1:0] exp_wb_data, rf_line;
    int            exp_stall, stalls, cnt, wb_seen, rf_seen;

    ix = a[8:5];
    tg = a[31:9];
    w  = int'(a[4:2]);
    hitm        = m_valid[ix] && (m_tag[ix] == tg);
    exp_wb      = !hitm && m_valid[ix] && m_dirty[ix];
    exp_wb_addr = {m_tag[ix], ix, 5'b0};
    exp_wb_data = m_data[ix];
    exp_rf_addr = {tg, ix, 5'b0};
    if (exp_wb) mem[exp_wb_addr] = m_data[ix];
    if (!hitm) begin
      m_data[ix]  = mem_get(exp_rf_addr);
      m_valid[ix] = 1'b1;
      m_dirty[ix] = 1'b0;
      m_tag[ix]   = tg;
    end
    rf_line   = m_data[ix];
    exp_stall = hitm ? 0 : (lat_rf + 2 + (exp_wb ? lat_wb : 0));
    exp_rdata = m_data[ix][w*32 +: 32];
    if (wr) begin
      m_data[ix][w*32 +: 32] = d;
      m_dirty[ix] = 1'b1;
    end

    @(negedge clk_i);
    cpu_addr_i     = a;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    cpu_data_i     = d;
    mem_ack_i      = 1'b0;
    done = 0; stalls = 0; cnt = 0; wb_seen = 0; rf_seen = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      #1;
      if (!cpu_stall_o) begin
        done = 1;
      end else begin
        stalls++;
        if (mem_enable_o) begin
          cnt++;
          if (mem_write_o ? (cnt == lat_wb) : (cnt == lat_rf)) begin
            if (mem_write_o) begin
              wb_seen++;
              chk("wb_addr", LW'(mem_addr_o), LW'(exp_wb_addr));
              chk("wb_data", mem_data_o, exp_wb_data);
            end else begin
              rf_seen++;
              chk("rf_addr", LW'(mem_addr_o), LW'(exp_rf_addr));
              mem_data_i = rf_line;
            end
            mem_ack_i = 1'b1;
            cnt = 0;
          end
        end
        @(negedge clk_i);
        mem_ack_i = 1'b0;
      end
    end
    if (!done) chk("stall_timeout", LW'(0), LW'(1));
    chk("stall_cycles", LW'(stalls), LW'(exp_stall));
    chk("writebacks", LW'(wb_seen), LW'(exp_wb ? 1 : 0));
    chk("refills", LW'(rf_seen), LW'(hitm ? 0 : 1));
    if (rd && !wr) chk("load_data", LW'(cpu_data_o), LW'(exp_rdata));
    @(posedge clk_i);
    #1;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_i          = 1'b1;
    cpu_addr_i     = 32'h400;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    cpu_data_i     = '0;
    mem_data_i     = '0;
    mem_ack_i      = 1'b0;
    model_reset();

    // Reset state: no memory request, stall follows req.
    #1;
    chk("rst_stall_noreq", LW'(cpu_stall_o), LW'(0));
    chk("rst_mem_en", LW'(mem_enable_o), LW'(0));
    chk("rst_mem_wr", LW'(mem_write_o), LW'(0));
    cpu_MemRead_i = 1'b1;
    #1;
    chk("rst_stall_req", LW'(cpu_stall_o), LW'(1));
    cpu_MemRead_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    cpu_MemWrite_i = 1'b1;
    #1;
    chk("post_rst_stall_req", LW'(cpu_stall_o), LW'(1));
    cpu_MemWrite_i = 1'b0;

    // Cold miss with 10-cycle ack: 12 stall cycles, word 0 of the fill.
    access(32'h0000_0400, 1, 0, 32'h0, 1, 10);
    chk("cold_word0", LW'(cpu_data_o), LW'(32'h0000_0400 ^ 32'hA5A5_0000));
    access(32'h0000_0404, 0, 1, 32'hDEAD_BEEF, 1, 1);
    access(32'h0000_0404, 1, 0, 32'h0, 1, 1);
    chk("store_readback", LW'(cpu_data_o), LW'(32'hDEAD_BEEF));

    // Conflict on a dirty line: write-back of 0x400 then refill 0x2400.
    access(32'h0000_2400, 1, 0, 32'h0, 4, 3);

    // Spurious ack with no request in IDLE.
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("spurious_mem_en", LW'(mem_enable_o), LW'(0));
    chk("spurious_stall", LW'(cpu_stall_o), LW'(0));
    access(32'h0000_2400, 1, 0, 32'h0, 1, 1);

    // Read+write together acts as a store.
    access(32'h0000_0408, 1, 0, 32'h0, 2, 2);
    access(32'h0000_0408, 1, 1, 32'h1234_5678, 1, 1);
    access(32'h0000_0408, 1, 0, 32'h0, 1, 1);
    chk("rdwr_store", LW'(cpu_data_o), LW'(32'h1234_5678));
    access(32'h0000_0404, 1, 0, 32'h0, 1, 1);
    chk("wb_kept_store", LW'(cpu_data_o), LW'(32'hDEAD_BEEF));

    // Reset in the middle of a refill aborts it.
    @(negedge clk_i);
    cpu_addr_i    = 32'h0000_0460;
    cpu_MemRead_i = 1'b1;
    #1;
    chk("abort_miss_stall", LW'(cpu_stall_o), LW'(1));
    @(negedge clk_i);
    #1;
    chk("abort_refill_en", LW'(mem_enable_o), LW'(1));
    chk("abort_refill_wr", LW'(mem_write_o), LW'(0));
    chk("abort_refill_addr", LW'(mem_addr_o), LW'(32'h0000_0460));
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    chk("abort_en_drop", LW'(mem_enable_o), LW'(0));
    cpu_MemRead_i = 1'b0;
    #1;
    chk("abort_idle", LW'(cpu_stall_o), LW'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    access(32'h0000_0408, 1, 0, 32'h0, 1, 3);

    // Randomized traffic over a few tags to mix hits, clean and dirty misses.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int          kind;
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) |
          ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      kind = $urandom_range(0, 3);
      access(a, kind != 1, kind != 0, $urandom, $urandom_range(1, 5), $urandom_range(1, 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter LINE_W, default 256, line width in bits (32-byte line).
REQ-003 SHALL have port clk_i, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port cpu_addr_i, input, 32, byte address from the MEM stage.
REQ-006 SHALL have port cpu_MemRead_i, input, 1, load request.
REQ-007 SHALL have port cpu_MemWrite_i, input, 1, store request.
REQ-008 SHALL have port cpu_data_i, input, 32, store data.
REQ-009 SHALL have port cpu_data_o, output, 32, load data, valid when a request is present and cpu_stall_o=0.
REQ-010 SHALL have port cpu_stall_o, output, 1, drives memStall_i of every pipeline register.
REQ-011 SHALL have ports mem_enable_o (1), mem_write_o (1), mem_addr_o (32), mem_data_o (LINE_W), outputs, line-granular memory request.
REQ-012 SHALL have ports mem_data_i (LINE_W) and mem_ack_i (1), inputs, refill data and one-cycle completion pulse.

Function
REQ-013 SHALL split the address as tag[31:9], index[8:5], offset[4:0]; word select = offset[4:2]; offset[1:0] ignored.
REQ-014 SHALL hold per line: valid bit, dirty bit, 23-bit tag, LINE_W data.
REQ-015 SHALL treat req = cpu_MemRead_i | cpu_MemWrite_i; both high is handled as a store.
REQ-016 SHALL define hit = req & valid[index] & (tag[index]==addr tag), combinational.
REQ-017 SHALL implement FSM states IDLE, WRITEBACK, REFILL, FILL_DONE.
REQ-018 IDLE: hit -> stay; cpu_stall_o=0; load returns selected word in the same cycle; store updates the word and sets dirty at the next edge.
REQ-019 IDLE: req & ~hit & valid & dirty -> WRITEBACK; req & ~hit & ~(valid & dirty) -> REFILL; cpu_stall_o=1 combinationally in the miss cycle.
REQ-020 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={old tag,index,5'b0}, mem_data_o=victim line; held constant until mem_ack_i, then -> REFILL.
REQ-021 REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={addr tag,index,5'b0}; on mem_ack_i capture mem_data_i into the line, set valid, clear dirty, write the tag, then -> FILL_DONE.
REQ-022 FILL_DONE: one cycle, cpu_stall_o=1, no memory request, -> IDLE; the request then completes as a hit.
REQ-023 cpu_stall_o SHALL be 1 in WRITEBACK, REFILL and FILL_DONE regardless of req.
REQ-024 mem_enable_o SHALL be 0 in IDLE and FILL_DONE; mem_ack_i outside WRITEBACK/REFILL is ignored.
REQ-025 Miss latency SHALL be (memory ack latency + 2) cycles for a clean miss; the dirty miss adds the write-back ack latency.
REQ-026 The CPU SHALL hold cpu_addr_i/control stable while cpu_stall_o=1; the block samples address live, with no latching.

Reset
REQ-027 rst_i SHALL asynchronously force state IDLE, clear all valid and dirty bits, and drive mem_enable_o=0 and mem_write_o=0.
REQ-028 Reset mid-WRITEBACK or mid-REFILL SHALL abort the transfer; data array contents are not cleared and are unreachable until refilled.
REQ-029 After reset, cpu_stall_o = req (every access misses).

Structure
REQ-030 SHALL place state encoding, address field widths and LINE_W in shared package dcache_pkg.
REQ-031 SHALL instantiate one sub-module dcache_sram: the data, tag, valid and dirty arrays with a single read/write port.
REQ-032 The FSM, hit compare and word mux/merge SHALL reside in dcache_ctrl.

Verification
REQ-033 Reset, then load 0x0000_0400 with memory ack after 10 cycles -> REFILL addr 0x400, stall for 12 cycles, then returns word 0 of the fill.
REQ-034 Store 0xDEADBEEF to 0x404 after the REFILL, then load 0x404 -> no stall, returns 0xDEADBEEF, dirty[0]=1.
REQ-035 Load 0x0000_2400 (same index, new tag) -> WRITEBACK addr 0x400 with the dirty line, then REFILL 0x2400.
REQ-036 Assert rst_i during REFILL -> mem_enable_o=0 immediately, state IDLE, next load to 0x400 misses.
REQ-037 Spurious mem_ack_i pulse in IDLE with no request -> no state change, mem_enable_o stays 0.
REQ-038 Assert cpu_MemRead_i and cpu_MemWrite_i together on a hit at 0x408 with data 0x12345678 -> treated as a store; a following load returns 0x12345678.
